ps2_key_ctrl: RTL
=================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 50000: ck cycles a prefix state may wait for its next byte.
REQ-003 SHALL have port ck  in  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_valid  in  1  one-cycle pulse, receiver byte available.
REQ-006 SHALL have port rx_data  in  8  received scancode byte, valid with rx_valid.
REQ-007 SHALL have port ev_ready  in  1  consumer accepts the head event.
REQ-008 SHALL have port clr_ovf  in  1  clears the overflow flag.
REQ-009 SHALL have port ev_valid  out  1  head event present.
REQ-010 SHALL have port ev_code  out  8  head event scancode.
REQ-011 SHALL have port ev_ext  out  1  head event carried E0 prefix.
REQ-012 SHALL have port ev_break  out  1  head event is a key release (F0 prefix).
REQ-013 SHALL have port fifo_count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
REQ-014 SHALL have port overflow  out  1  sticky, an event was dropped.

Function
REQ-015 SHALL decode with FSM states IDLE, GOT_E0, GOT_F0, GOT_E0F0, advancing only on cycles with rx_valid=1.
REQ-016 IDLE: E0 -> GOT_E0; F0 -> GOT_F0; any other byte -> push {ext=0,brk=0,code}, stay IDLE.
REQ-017 GOT_E0: F0 -> GOT_E0F0; E0 -> stay GOT_E0; other -> push {1,0,code}, -> IDLE.
REQ-018 GOT_F0: E0 or F0 -> discard, -> IDLE; other -> push {0,1,code}, -> IDLE.
REQ-019 GOT_E0F0: E0 or F0 -> discard, -> IDLE; other -> push {1,1,code}, -> IDLE.
REQ-020 Bytes 00 and FF (keyboard error) SHALL be discarded in every state and force IDLE, no push.
REQ-021 Timeout counter SHALL clear on every rx_valid and in IDLE, increment each cycle in other states; on reaching TIMEOUT-1 the FSM SHALL return to IDLE with no push.
REQ-022 FIFO SHALL be first-word-fall-through: ev_valid = (fifo_count != 0); ev_code/ev_ext/ev_break show head entry.
REQ-023 When ev_valid=0, ev_code, ev_ext, ev_break SHALL be 0.
REQ-024 Pop SHALL occur on cycles with ev_valid=1 and ev_ready=1; ev_ready while empty SHALL have no effect.
REQ-025 Latency: decoded byte on rx_valid at edge N into empty FIFO SHALL give ev_valid=1 after edge N+1 (next cycle).
REQ-026 Push while full without same-cycle pop SHALL drop the event, leave FIFO unchanged, and set overflow.
REQ-027 Push and pop in same cycle SHALL both take effect, including when full; fifo_count unchanged.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH.
REQ-029 clr_ovf SHALL clear overflow next cycle; a same-cycle drop SHALL win (overflow stays 1).

Reset
REQ-030 reset=1 SHALL asynchronously force FSM IDLE, timeout counter 0, pointers 0, fifo_count 0, overflow 0, ev_valid 0, ev_code 0, ev_ext 0, ev_break 0.
REQ-031 reset mid-sequence (prefix pending, FIFO non-empty) SHALL discard pending prefix and all stored events; first byte after release is decoded from IDLE.

Structure
REQ-032 Shared package ps2_pkg SHALL hold FSM state enum, constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF, and the 10-bit event typedef {ext, brk, code}.
REQ-033 FIFO SHALL be a sub-module ps2_evt_fifo (DEPTH parameter, push/pop/full/empty/count); decoder FSM and timeout live in ps2_key_ctrl.

Verification
REQ-034 Bytes 1C -> one event {code=1C, ext=0, brk=0}, ev_valid high one cycle after rx_valid.
REQ-035 Bytes E0,F0,75 with ev_ready=1 -> single event {75,1,1}; no events for prefix bytes.
REQ-036 ev_ready=0, five bytes 16,1E,26,25,2E with DEPTH=4 -> fifo_count=4, overflow=1, drained order 16,1E,26,25.
REQ-037 F0 then no byte for TIMEOUT cycles, then 1C -> event {1C,0,0} (prefix expired).
REQ-038 Full FIFO, push and pop same cycle -> fifo_count stays 4, overflow stays 0; clr_ovf with simultaneous drop -> overflow=1.
REQ-039 reset asserted after E0 with 2 events stored -> ev_valid=0, fifo_count=0 immediately; then 74 -> event {74,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 keyboard scancode decoder shared types.
// Holds the prefix FSM states, the special byte values and the event word.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic ps2_is_err(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

    function automatic logic ps2_is_pfx(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO for decoded key events.
// A push into a full FIFO only lands when a pop frees a slot that cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   push_i,
    input  ps2_evt_t               din_i,
    input  logic                   pop_i,
    output ps2_evt_t               dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;
    ps2_evt_t      mem_q [DEPTH];

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Qualify push/pop and advance pointers; power-of-two depth wraps for free.
    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are never visible while empty, so no reset.
    always_ff @(posedge ck) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode prefix decoder feeding a key event FIFO.
// E0/F0 prefixes are folded into ext/brk flags; stale prefixes time out.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   ev_ready,
    input  logic                   clr_ovf,
    output logic                   ev_valid,
    output logic [7:0]             ev_code,
    output logic                   ev_ext,
    output logic                   ev_break,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          expired;
    logic          push, drop, full, empty;
    ps2_evt_t      evt, head;

    // Prefix decoder: builds the event word and picks the next state.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        evt     = '0;
        expired = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
        if (rx_valid) begin
            if (ps2_is_err(rx_data)) begin
                state_d = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_data == PS2_EXT) begin
                            state_d = ST_GOT_E0;
                        end else if (rx_data == PS2_BRK) begin
                            state_d = ST_GOT_F0;
                        end else begin
                            push = 1'b1;
                            evt  = {1'b0, 1'b0, rx_data};
                        end
                    end
                    ST_GOT_E0: begin
                        if (rx_data == PS2_BRK) begin
                            state_d = ST_GOT_E0F0;
                        end else if (rx_data != PS2_EXT) begin
                            state_d = ST_IDLE;
                            push    = 1'b1;
                            evt     = {1'b1, 1'b0, rx_data};
                        end
                    end
                    ST_GOT_F0: begin
                        state_d = ST_IDLE;
                        push    = !ps2_is_pfx(rx_data);
                        evt     = {1'b0, 1'b1, rx_data};
                    end
                    ST_GOT_E0F0: begin
                        state_d = ST_IDLE;
                        push    = !ps2_is_pfx(rx_data);
                        evt     = {1'b1, 1'b1, rx_data};
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (expired) begin
            state_d = ST_IDLE;
        end
        if (rx_valid || state_q == ST_IDLE || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Sticky overflow: a dropped event outranks a clear request.
    always_comb begin
        drop  = push && full && !(ev_ready && !empty);
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Decoder state, timeout counter and overflow flag.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck      (ck),
        .reset   (reset),
        .push_i  (push),
        .din_i   (evt),
        .pop_i   (ev_ready),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    assign ev_valid = !empty;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_break = head.brk;
    assign overflow = ovf_q;

endmodule
